// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream multiplexer with a registered output.
// A channel is chosen either by the external select (mode = 0) or, when the
// STREAM_MUX_RR_EN macro is defined, by round-robin arbitration (mode = 1).
// Without STREAM_MUX_RR_EN the round-robin pointer and scan logic are left out,
// mode is ignored and the external select is always used. The port list is the
// same in both builds.
module stream_mux_rr #(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SELW     = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      mode,
    input  logic [SELW-1:0]           sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SELW-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [SELW-1:0]   chan_q,  chan_d;

    logic              sel_vld;
    logic [SELW-1:0]   sel_idx;
    logic              grant_vld;
    logic [SELW-1:0]   grant_idx;
    logic [WIDTH-1:0]  grant_data;
    logic              can_load;
    logic              take;

    // External-select grant: an index with no matching channel never grants.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
                sel_vld = 1'b1;
                sel_idx = SELW'(i);
            end
        end
    end

`ifdef STREAM_MUX_RR_EN
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic              rr_vld;
    logic [SELW-1:0]   rr_idx;
    logic [SELW:0]     rr_sum;

    // Round-robin scan from ptr upward with wrap; walking from the farthest
    // candidate back to ptr lets the nearest valid channel win.
    always_comb begin
        rr_vld = 1'b0;
        rr_idx = '0;
        rr_sum = '0;
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            rr_sum = {1'b0, ptr_q} + (SELW+1)'(k);
            if (rr_sum >= (SELW+1)'(CHANNELS)) begin
                rr_sum = rr_sum - (SELW+1)'(CHANNELS);
            end
            if (in_valid[rr_sum[SELW-1:0]]) begin
                rr_vld = 1'b1;
                rr_idx = rr_sum[SELW-1:0];
            end
        end
    end

    // Grant source follows mode in the same cycle it changes.
    always_comb begin
        if (mode) begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end else begin
            grant_vld = sel_vld;
            grant_idx = sel_idx;
        end
    end

    // Pointer moves past the granted channel on every accepted word, in
    // either mode, so round-robin resumes fairly after a mode switch.
    always_comb begin
        ptr_d = ptr_q;
        if (take) begin
            if (grant_idx == SELW'(CHANNELS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + SELW'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = mode;

    // Only the external select exists in this build.
    always_comb begin
        grant_vld = sel_vld;
        grant_idx = sel_idx;
    end
`endif

    // The output register can take a word when empty or when being drained.
    // Reset forces in_ready low so nothing is accepted in the reset cycle.
    always_comb begin
        can_load = (state_q == ST_EMPTY) || out_ready;
        take     = reset_n && can_load && grant_vld;
    end

    // One-hot ready back to the granted channel only.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            in_ready[i] = take && (grant_idx == SELW'(i));
        end
    end

    // Data of the granted channel; in_data only feeds the register, never
    // an output directly.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output-stage next state: load on accept, drop to empty when drained
    // without a reload, otherwise hold the word stable.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        case (state_q)
            ST_EMPTY: begin
                if (take) begin
                    state_d = ST_FULL;
                    data_d  = grant_data;
                    chan_d  = grant_idx;
                end
            end
            ST_FULL: begin
                if (take) begin
                    data_d  = grant_data;
                    chan_d  = grant_idx;
                end else if (out_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Output register; reset clears the held word as well as the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_chan  = chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Testbench for stream_mux_rr: directed scenarios followed by random traffic,
// checked by a transaction-level reference model and an output scoreboard.
module tb_stream_mux_rr;

    localparam int W    = 16;
    localparam int CH   = 4;
    localparam int SELW = 2;
`ifdef STREAM_MUX_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic                clk;
    logic                reset_n;
    logic                mode;
    logic [SELW-1:0]     sel;
    logic [CH*W-1:0]     in_data;
    logic [CH-1:0]       in_valid;
    logic [CH-1:0]       in_ready;
    logic [W-1:0]        out_data;
    logic [SELW-1:0]     out_chan;
    logic                out_valid;
    logic                out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard of words expected at the output, {chan, data}
    logic [SELW+W-1:0] sb_q[$];
    // Reference model state
    bit m_full = 0;
    int m_ptr  = 0;

    stream_mux_rr #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int c, input logic [W-1:0] v);
        in_data[c*W +: W] = v;
    endtask

    // Reference model: decides the grant from the rules (first valid channel
    // at or after ptr in round-robin, else sel), checks handshake/control and
    // queues the word that must later appear at the output.
    always @(negedge clk) begin
        int g;
        int c;
        bit can;
        logic [CH-1:0] exp_rdy;
        if (!reset_n) begin
            chk("ready_in_reset", in_ready, '0);
            sb_q.delete();
            m_full = 0;
            m_ptr  = 0;
        end else begin
            g = -1;
            if (RR_EN && mode) begin
                for (int d = 0; d < CH; d++) begin
                    c = (m_ptr + d) % CH;
                    if (g < 0 && in_valid[c]) g = c;
                end
            end else if (int'(sel) < CH && in_valid[sel]) begin
                g = int'(sel);
            end
            can = !m_full || out_ready;
            exp_rdy = (can && g >= 0) ? CH'(1 << g) : '0;
            chk("in_ready", in_ready, exp_rdy);
            chk("out_valid", out_valid, m_full);
            if (exp_rdy != '0) begin
                sb_q.push_back({SELW'(g), in_data[g*W +: W]});
                m_full = 1;
                m_ptr  = (g + 1) % CH;
            end else if (m_full && out_ready) begin
                m_full = 0;
            end
        end
    end

    // Output monitor: every word taken by the consumer must match the
    // oldest queued expectation.
    always @(negedge clk) begin
        logic [SELW+W-1:0] e;
        if (reset_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                chk("sb_data", out_data, e[W-1:0]);
                chk("sb_chan", out_chan, e[SELW+W-1:W]);
            end
        end
    end

    initial begin
        int ec;
        reset_n   = 1'b0;
        mode      = 1'b0;
        sel       = '0;
        in_valid  = '1;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held two cycles with every channel valid
        repeat (2) begin
            cycle();
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_data", out_data, 16'h0000);
            chk("rst_out_chan", out_chan, 2'd0);
            chk("rst_in_ready", in_ready, 4'b0000);
        end

        // External select streaming
        reset_n = 1'b1; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
        set_ch(2, 16'hBEEF); out_ready = 1'b1;
        #1 chk("sel_ready", in_ready, 4'b0100);
        cycle();
        chk("sel_data", out_data, 16'hBEEF);
        chk("sel_chan", out_chan, 2'd2);
        chk("sel_valid", out_valid, 1'b1);
        sel = 2'd3;
        #1 chk("sel_invalid_ready", in_ready, 4'b0000);
        cycle();
        chk("sel_drained", out_valid, 1'b0);

        // Backpressure
        sel = 2'd0; in_valid = 4'b0001; set_ch(0, 16'h1234);
        #1 chk("bp_load_ready", in_ready, 4'b0001);
        cycle();
        chk("bp_loaded", out_data, 16'h1234);
        out_ready = 1'b0; set_ch(0, 16'h5678);
        repeat (3) begin
            #1 chk("bp_ready_low", in_ready, 4'b0000);
            chk("bp_hold", out_data, 16'h1234);
            cycle();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", in_ready, 4'b0001);
        cycle();
        chk("bp_reload_data", out_data, 16'h5678);
        chk("bp_reload_valid", out_valid, 1'b1);
        in_valid = '0;
        cycle();

        // Round-robin from a fresh pointer (config-off build: always sel = 1)
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1; mode = 1'b1; sel = 2'd1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int k = 0; k < CH; k++) set_ch(k, W'(16'h00A0 + k));
        for (int k = 0; k < 6; k++) begin
            cycle();
            ec = RR_EN ? (k % CH) : 1;
            chk("rr_chan", out_chan, ec);
            chk("rr_data", out_data, 16'h00A0 + ec);
        end

        // Skip and wrap: move ptr to 3, then grant 1, then 3, then 0
        in_valid = 4'b0100;
        #1 chk("rr_to_ptr3", in_ready, RR_EN ? 4'b0100 : 4'b0000);
        cycle();
        in_valid = 4'b0010;
        #1 chk("rr_skip", in_ready, 4'b0010);
        cycle();
        in_valid = 4'b1001;
        #1 chk("rr_grant3", in_ready, RR_EN ? 4'b1000 : 4'b0000);
        cycle();
        #1 chk("rr_wrap0", in_ready, RR_EN ? 4'b0001 : 4'b0000);
        cycle();
        in_valid = '0;
        repeat (2) cycle();

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            reset_n   = ($urandom_range(0, 99) != 0);
            mode      = 1'($urandom);
            sel       = SELW'($urandom);
            in_valid  = CH'($urandom);
            for (int k = 0; k < CH; k++) set_ch(k, W'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        // Drain and confirm nothing expected is left
        reset_n = 1'b1; in_valid = '0; out_ready = 1'b1;
        repeat (3) cycle();
        chk("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N:1 datapath multiplexer with per-channel valid/ready handshakes and a registered output stage. It generalises the processor's 2:1 and 3-bit select muxes to CHANNELS inputs of WIDTH bits. Selection is either by an externally driven select, as the existing muxes do, or by round-robin arbitration among requesting channels. It sits between multiple bus sources (register file, ALU, memory read-back, I/O) and a single consumer such as the bus or writeback path, and provides backpressure instead of silently overwriting data.

## Interface
Parameters:
- WIDTH, 16, data width per channel (≥1)
- CHANNELS, 4, number of input channels (≥2)
- SELW, $clog2(CHANNELS), derived localparam; never overridden

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  reset; synchronous and active-low (sampled on rising clk)
- mode  input  1  0 = external select, 1 = round-robin (see Configuration)
- sel  input  SELW  channel index used when mode = 0
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  channel i presents a word
- in_ready  output  CHANNELS  channel i word is accepted this cycle
- out_data  output  WIDTH  registered output word
- out_chan  output  SELW  index of the channel that supplied out_data
- out_valid  output  1  out_data holds an untaken word
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Output register has two states:
  - EMPTY (out_valid = 0)
  - FULL (out_valid = 1)
- can_load = !out_valid || out_ready.
- Grant is combinational:
  - mode 0: grant = sel if sel < CHANNELS and in_valid[sel]; otherwise no grant. An out-of-range sel never grants.
  - mode 1: scan channels starting at ptr, upward with wrap, and grant the first i with in_valid[i]. If no channel is valid, there is no grant.
- in_ready[i] = can_load && (grant == i). At most one bit of in_ready is set.
- Transfer-in (in_valid[g] && in_ready[g]):
  - out_data <= channel g data, out_chan <= g, out_valid <= 1
  - ptr <= (g == CHANNELS-1) ? 0 : g+1
- Transfer-out (out_valid && out_ready) with no transfer-in: out_valid <= 0, so the register goes FULL→EMPTY. out_data and out_chan hold their values.
- Simultaneous transfer-out and transfer-in: the register stays FULL and is reloaded, giving 1 word/cycle throughput.
- FULL && !out_ready: in_ready is all zero; out_data and out_chan are stable until taken.
- ptr advances only on transfer-in, in either mode, so round-robin resumes fairly after a mode switch.
- mode and sel take effect in the same cycle they change. A word already in the output register is unaffected.
- Reset (reset_n = 0 at a clk edge) is valid mid-transfer:
  - out_valid = 0, out_data = 0, out_chan = 0, ptr = 0
  - any held word is discarded
  - in_ready is 0 during the reset cycle

## Timing
- Latency: input accepted at edge N appears on out_data/out_valid after edge N.
- Throughput: 1 word per cycle when out_ready stays high.
- in_ready depends combinationally on in_valid, sel, mode and out_ready. There is no combinational path from in_data to any output.
- Round-robin fairness: with all channels continuously valid, each channel is granted exactly once per CHANNELS consecutive transfers.

## Configuration
- Macro: STREAM_MUX_RR_EN
- Defined: round-robin logic and ptr are compiled in, and mode behaves as described.
- Undefined: ptr and the scan logic are omitted. mode is ignored and the block always uses external select (mode 0 behaviour). Port list is unchanged.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles with all in_valid = 1 → out_valid = 0, out_data = 0x0000, out_chan = 0, in_ready = 4'b0000.
- Select mode, streaming: mode = 0, sel = 2, in_valid = 4'b0100, ch2 = 0xBEEF, out_ready = 1 → in_ready = 4'b0100; next cycle out_data = 0xBEEF, out_chan = 2, out_valid = 1. Setting sel = 3 with in_valid[3] = 0 → in_ready = 0.
- Backpressure: FULL with 0x1234 and out_ready = 0 for 3 cycles while ch0 is valid → in_ready = 0 and out_data stays 0x1234. Raising out_ready → 0x1234 is taken and ch0 data is loaded in the same cycle.
- Round-robin: mode = 1, all four valid with data 0xA0..0xA3, out_ready = 1 → out_chan sequence 0,1,2,3,0,1, one per cycle.
- Round-robin skip and wrap: ptr = 3, in_valid = 4'b0010 → grant 1 and ptr becomes 2. Then in_valid = 4'b1001 → grant 3, then 0.
- Config off: build without STREAM_MUX_RR_EN, mode = 1, sel = 1, all valid → every transfer is from ch1.
